// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - per-register countdown scoreboard driving ID-stage stall
//
// Optional feature macro: HAZARD_STALL_CNT_EN (enables the saturating stall_count counter).
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   freeze              global pipeline hold; scoreboard state holds
//   flush               ID instruction squashed this cycle; it does not issue
//   fwd_en              1 = forwarding present, stall only on load-use
//   id_valid            ID holds a real instruction
//   src1, src2          source registers of the ID instruction
//   is_immediate        src2 not read unless st_or_bne
//   st_or_bne           src2 read even in immediate format
//   id_wb_en            ID instruction writes id_dest
//   id_dest             destination register of the ID instruction
//   id_mem_r_en         ID instruction is a load
//   hazard_detected     stall ID this cycle (combinational)
//   pending_mask        bit r set while register r has an in-flight write
//   stall_count         saturating stall-cycle counter (zero without the macro)
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_REGS    = 32,
    parameter int WB_LATENCY  = 2,
    parameter int CNT_W       = $clog2(WB_LATENCY + 1),
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   fwd_en,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  src1,
    input  logic [REG_ADDR_W-1:0]  src2,
    input  logic                   is_immediate,
    input  logic                   st_or_bne,
    input  logic                   id_wb_en,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   id_mem_r_en,
    output logic                   hazard_detected,
    output logic [NUM_REGS-1:0]    pending_mask,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LATENCY);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] is_load;

    logic use1, use2, hit1, hit2, issue;

    assign use1 = id_valid;
    assign use2 = id_valid & (~is_immediate | st_or_bne);

    // Register 0 is skipped by starting the scan at 1, so a zero source never hits.
    always_comb begin
        logic busy;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            // With forwarding, only a load still in EXE (counter just loaded) is unresolvable.
            busy = fwd_en ? (is_load[r] && (cnt[r] == LAT)) : (cnt[r] != '0);
            if (use1 && (src1 == REG_ADDR_W'(r)) && busy) hit1 = 1'b1;
            if (use2 && (src2 == REG_ADDR_W'(r)) && busy) hit2 = 1'b1;
        end
    end

    assign hazard_detected = hit1 | hit2;
    assign issue           = id_valid & ~hazard_detected & ~freeze & ~flush;

    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            is_load <= '0;
        end else if (!freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                    if (cnt[r] == CNT_W'(1)) is_load[r] <= 1'b0;
                end
                // A new issue to the same register wins over the decrement above.
                if ((r != 0) && issue && id_wb_en && (id_dest == REG_ADDR_W'(r))) begin
                    cnt[r]     <= LAT;
                    is_load[r] <= id_mem_r_en;
                end
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (id_valid && hazard_detected && !freeze && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - scoreboard-checked directed bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, fwd_en, id_valid;
    logic [4:0]  src1, src2, id_dest;
    logic        is_immediate, st_or_bne, id_wb_en, id_mem_r_en;
    logic        hazard_detected;
    logic [31:0] pending_mask;
    logic [3:0]  stall_count;

    typedef struct {
        string       name;
        logic        hz;
        logic [31:0] mask;
        logic        chk_sc;
        logic [3:0]  sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(
        .REG_ADDR_W(5), .NUM_REGS(32), .WB_LATENCY(2), .STALL_CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
        .id_valid(id_valid), .src1(src1), .src2(src2), .is_immediate(is_immediate),
        .st_or_bne(st_or_bne), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .id_mem_r_en(id_mem_r_en), .hazard_detected(hazard_detected),
        .pending_mask(pending_mask), .stall_count(stall_count)
    );

    // Monitor: outputs are sampled mid-cycle, one expectation per stimulated cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if (hazard_detected !== e.hz)
                $display("FAIL %s.hazard: got %0b expected %0b", e.name, hazard_detected, e.hz);
            else if (pending_mask !== e.mask)
                $display("FAIL %s.mask: got %h expected %h", e.name, pending_mask, e.mask);
            else if (e.chk_sc && stall_count !== e.sc)
                $display("FAIL %s.stall_count: got %0d expected %0d", e.name, stall_count, e.sc);
            else
                n_passed++;
        end
    end

    // Drive one cycle of ID inputs (caller is just past a posedge) and queue the expected outputs.
    task automatic step(input string name, input bit v, input logic [4:0] s1, input logic [4:0] s2,
                        input bit imm, input bit sob, input bit wb, input logic [4:0] d,
                        input bit ld, input bit fr, input bit fl, input bit r,
                        input bit ehz, input logic [31:0] emask,
                        input bit csc = 1'b0, input logic [3:0] esc = 4'd0);
        exp_t e;
        id_valid = v; src1 = s1; src2 = s2; is_immediate = imm; st_or_bne = sob;
        id_wb_en = wb; id_dest = d; id_mem_r_en = ld; freeze = fr; flush = fl; rst = r;
        e.name = name; e.hz = ehz; e.mask = emask; e.chk_sc = csc; e.sc = esc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] M3  = 32'h1 << 3;
    localparam logic [31:0] M4  = 32'h1 << 4;
    localparam logic [31:0] M5  = 32'h1 << 5;
    localparam logic [31:0] M10 = 32'h1 << 10;

`ifdef HAZARD_STALL_CNT_EN
    localparam logic [3:0] SAT_SC = 4'd15;
`else
    localparam logic [3:0] SAT_SC = 4'd0;
`endif

    initial begin
        rst = 1'b1; freeze = 0; flush = 0; fwd_en = 0; id_valid = 0;
        src1 = 0; src2 = 0; id_dest = 0; is_immediate = 1; st_or_bne = 0;
        id_wb_en = 0; id_mem_r_en = 0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 4'd0);

        // Dependent ALU op without forwarding: two stall cycles.
        fwd_en = 0;
        step("alu_issue", 1, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 32'h0);
        step("alu_dep0",  1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, M3);
        step("alu_dep1",  1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, M3);
        step("alu_dep2",  1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Forwarding: ALU producer never stalls, load producer stalls once.
        fwd_en = 1;
        step("fwd_alu_issue", 1, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 32'h0);
        step("fwd_alu_dep",   1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, M3);
        step("fwd_idle",      0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, M3);
        step("fwd_ld_issue",  1, 0, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 32'h0);
        step("fwd_ld_dep0",   1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, M3);
        step("fwd_ld_dep1",   1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, M3);
        step("fwd_ld_idle",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Immediate format: src2 only counts with st_or_bne.
        fwd_en = 0;
        step("imm_issue",  1, 0, 0, 1, 0, 1, 4, 0, 0, 0, 0, 0, 32'h0);
        step("imm_nosrc2", 1, 7, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, M4);
        step("imm_stbne",  1, 7, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, M4);
        step("imm_idle",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Register 0 is never tracked.
        step("r0_write", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        step("r0_read",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Freeze holds the scoreboard; hazard persists until two live cycles pass.
        step("frz_issue", 1, 0, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++)
            step("frz_hold", 1, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, M5);
        step("frz_rel0", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, M5);
        step("frz_rel1", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, M5);
        step("frz_rel2", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Flushed write must not create an entry.
        step("flush_wr",  1, 0, 0, 1, 0, 1, 6, 0, 0, 1, 0, 0, 32'h0);
        step("flush_chk", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Stall counter: clear, then self-dependent op gives pattern issue,stall,stall x10.
        step("sc_rst", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 30; i++)
            step("sc_loop", 1, 9, 0, 1, 0, 1, 9, 0, 0, 0, 0, (i % 3) != 0,
                 ((i % 3) == 0) ? 32'h0 : (32'h1 << 9));
        step("sc_sat", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, SAT_SC);

        // Mid-operation reset discards pending entries and the counter.
        step("mid_issue", 1, 0, 0, 1, 0, 1, 10, 0, 0, 0, 0, 0, 32'h0, 1, SAT_SC);
        step("mid_rst",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, M10);
        step("mid_after", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 4'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
